// File: rtl/ahb_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_master_pkg
//  Description : Shared constants for the AHB command master: FSM state
//                encodings, HADDR field positions and default widths.
//  Revision    : 1.0  initial release
// ============================================================================
package ahb_master_pkg;

    localparam int ADDR_W_DEF     = 7;
    localparam int DATA_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TIMEOUT_DEF    = 16;

    // HADDR layout: [SLV_MSB:SLV_LSB] selects the APB slave, [PADDR_MSB:0] is PADDR
    localparam int SLV_MSB   = 6;
    localparam int SLV_LSB   = 5;
    localparam int PADDR_MSB = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_DATA = 2'd2;

    function automatic logic [SLV_MSB-SLV_LSB:0] slave_of(input logic [SLV_MSB:0] addr);
        return addr[SLV_MSB:SLV_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with occupancy count; a push while full is
//                refused regardless of a same-cycle pop.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                  c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]    c_FULL  = (c_PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == c_FULL);
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Depth is a power of two, so the pointers wrap by natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ahb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_cmd_master
//  Description : AHB-Lite master turning buffered CPU commands into single
//                transfers (address phase, data phase) with timeout abort.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_cmd_master
    import ahb_master_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              HCLK,
    input  logic              RESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [DATA_W-1:0] HWDATA,
    output logic              HREADY,
    input  logic              HREADYOUT,
    input  logic [DATA_W-1:0] HRDATA
);

    localparam int                 c_ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam int                 c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam int                 c_OCC_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_head_write;
    logic [ADDR_W-1:0]    w_head_addr;
    logic [DATA_W-1:0]    w_head_wdata;
    logic                 w_full;
    logic [c_OCC_W-1:0]   w_count;
    logic                 w_has_cmd;
    logic                 w_pop;
    logic                 w_done;
    logic                 w_tmo;
    logic [c_CNT_W-1:0]   w_wait_inc;
    state_t               w_state_nxt;

    state_t               r_state;
    logic                 r_hsel;
    logic [ADDR_W-1:0]    r_haddr;
    logic                 r_hwrite;
    logic [DATA_W-1:0]    r_hwdata;
    logic [DATA_W-1:0]    r_wdata_hold;
    logic [c_CNT_W-1:0]   r_wait_cnt;
    logic                 r_rsp_valid;
    logic                 r_rsp_write;
    logic                 r_rsp_err;
    logic [DATA_W-1:0]    r_rsp_rdata;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk     (HCLK),
        .rst     (RESET),
        .i_push  (cmd_valid),
        .i_wdata ({cmd_write, cmd_addr, cmd_wdata}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_count (w_count)
    );

    assign {w_head_write, w_head_addr, w_head_wdata} = w_head;
    assign w_has_cmd  = (w_count != '0);
    assign w_wait_inc = r_wait_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_has_cmd && HREADYOUT) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (HREADYOUT) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_wait_inc == c_TIMEOUT) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus and response registers; HADDR/HWRITE only move when a command is popped
    always_ff @(posedge HCLK or posedge RESET) begin
        if (RESET) begin
            r_hsel       <= 1'b0;
            r_haddr      <= '0;
            r_hwrite     <= 1'b0;
            r_hwdata     <= '0;
            r_wdata_hold <= '0;
            r_wait_cnt   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_write  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
        end else begin
            r_rsp_valid <= w_done || w_tmo;
            if (w_pop) begin
                r_hsel       <= 1'b1;
                r_haddr      <= w_head_addr;
                r_hwrite     <= w_head_write;
                r_wdata_hold <= w_head_wdata;
            end
            if (r_state == ST_ADDR) begin
                r_hsel     <= 1'b0;
                r_hwdata   <= r_hwrite ? r_wdata_hold : '0;
                r_wait_cnt <= '0;
            end
            if ((r_state == ST_DATA) && !HREADYOUT) begin
                r_wait_cnt <= w_wait_inc;
            end
            if (w_done) begin
                r_rsp_write <= r_hwrite;
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= r_hwrite ? '0 : HRDATA;
            end
            if (w_tmo) begin
                r_rsp_write <= r_hwrite;
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign cmd_ready = !w_full;
    assign HSEL      = r_hsel;
    assign HADDR     = r_haddr;
    assign HWRITE    = r_hwrite;
    assign HWDATA    = r_hwdata;
    assign HREADY    = HREADYOUT;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_cmd_master
//  Description : Randomized scoreboard bench for ahb_cmd_master with a
//                bench-side slave model and response queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_cmd_master;

    localparam int TMO   = 16;
    localparam int DEPTH = 4;

    typedef struct {
        bit          w;
        logic [6:0]  a;
        logic [31:0] d;
    } cmd_t;

    typedef struct {
        bit          w;
        bit          e;
        logic [31:0] r;
    } rsp_t;

    logic        HCLK;
    logic        RESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        HSEL;
    logic [6:0]  HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    ahb_cmd_master #(
        .ADDR_W     (7),
        .DATA_W     (32),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .HCLK      (HCLK),
        .RESET     (RESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks   = 0;
    int failures = 0;

    cmd_t cmd_q[$];
    rsp_t exp_q[$];

    // slave model state
    bit          in_data    = 0;
    bit          fin        = 0;
    bit          prev_hsel  = 0;
    int          dk, lc, nwait;
    logic [31:0] hrd;
    cmd_t        cur;
    int          force_n    = -1;
    bit          force_rd_en = 0;
    logic [31:0] force_rd   = '0;
    int          idle_mode  = 1;   // 0 random, 1 ready, 2 stalled
    int          cyc        = 0;
    int          last_hsel_cyc = -100;
    int          n_acc      = 0;
    int          n_iss      = 0;
    rsp_t        mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        HRDATA = $urandom;
        case (idle_mode)
            1:       HREADYOUT = 1'b1;
            2:       HREADYOUT = 1'b0;
            default: HREADYOUT = (($urandom % 8) != 0);
        endcase
    endtask

    // One negedge: act as slave, check occupancy, then offer a command
    task automatic step(input bit offer, input bit w, input logic [6:0] a, input logic [31:0] d);
        rsp_t e;
        bit   rdy;
        int   occ;
        @(negedge HCLK);
        cyc++;
        if (HSEL === 1'b1) begin
            chk("hsel_single_cycle", 32'(prev_hsel), 0);
            chk("hsel_spacing", 32'(cyc - last_hsel_cyc >= 3), 1);
            if (cmd_q.size() == 0) begin
                chk("hsel_without_cmd", 1, 0);
                cur = '{w: 1'b0, a: '0, d: '0};
            end else begin
                cur = cmd_q.pop_front();
                chk("haddr_order", 32'(HADDR), 32'(cur.a));
                chk("hwrite_order", 32'(HWRITE), 32'(cur.w));
            end
            if (force_n >= 0)            nwait = force_n;
            else begin
                case ($urandom % 10)
                    0:       nwait = TMO + int'($urandom % 3);
                    1:       nwait = TMO - 1;
                    default: nwait = int'($urandom % 4);
                endcase
            end
            hrd = force_rd_en ? force_rd : $urandom;
            e.w = cur.w;
            e.e = (nwait >= TMO);
            e.r = (e.e || cur.w) ? 32'h0 : hrd;
            exp_q.push_back(e);
            in_data = 1; fin = 0; dk = 0; lc = 0;
            n_iss++;
            last_hsel_cyc = cyc;
            HREADYOUT = $urandom;
            HRDATA    = $urandom;
        end else if (in_data) begin
            if (fin) begin
                in_data = 0;
                drive_idle();
            end else begin
                chk("hwdata_data_phase", HWDATA, cur.w ? cur.d : 32'h0);
                chk("haddr_held", 32'(HADDR), 32'(cur.a));
                rdy = (dk >= nwait);
                HREADYOUT = rdy;
                HRDATA    = rdy ? hrd : $urandom;
                if (rdy) fin = 1;
                else begin
                    lc++;
                    if (lc == TMO) fin = 1;
                end
                dk++;
            end
        end else begin
            drive_idle();
        end
        prev_hsel = (HSEL === 1'b1);
        occ = n_acc - n_iss;
        chk("cmd_ready", 32'(cmd_ready), 32'(occ < DEPTH));
        cmd_valid = offer;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        if (offer && cmd_ready === 1'b1) begin
            cmd_q.push_back('{w: w, a: a, d: d});
            n_acc++;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || cmd_q.size() != 0 || in_data) && k < 600) begin
            step(0, 0, '0, '0);
            k++;
        end
        chk("drain_bound", 32'(k < 600), 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_hsel"},   32'(HSEL), 0);
        chk({tag, "_haddr"},  32'(HADDR), 0);
        chk({tag, "_hwrite"}, 32'(HWRITE), 0);
        chk({tag, "_hwdata"}, HWDATA, 0);
        chk({tag, "_rsp"},    32'({rsp_valid, rsp_write, rsp_err}), 0);
        chk({tag, "_rdata"},  rsp_rdata, 0);
        chk({tag, "_ready"},  32'(cmd_ready), 1);
    endtask

    task automatic reset_in_data();
        int k = 0;
        force_n = 10;
        while (!(in_data && !fin && HSEL === 1'b0) && k < 200) begin
            step(k == 0, $urandom % 2, $urandom, $urandom);
            k++;
        end
        chk("reach_data_phase", 32'(in_data && !fin), 1);
        RESET = 1'b1;
        #1;
        chk_outputs_zero("mid_reset");
        cmd_q.delete();
        exp_q.delete();
        in_data = 0; fin = 0; prev_hsel = 0; n_acc = 0; n_iss = 0;
        cmd_valid = 1'b0;
        force_n = -1;
        step(0, 0, '0, '0);
        step(0, 0, '0, '0);
        RESET = 1'b0;
    endtask

    always @(negedge HCLK) begin
        if (RESET === 1'b0 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_write", 32'(rsp_write), 32'(mon_e.w));
                chk("rsp_err",   32'(rsp_err),   32'(mon_e.e));
                chk("rsp_rdata", rsp_rdata,      mon_e.r);
            end
        end
    end

    initial begin
        int c0;
        int base;
        RESET     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        HREADYOUT = 1'b1;
        HRDATA    = '0;
        repeat (5) @(negedge HCLK);
        chk_outputs_zero("in_reset");
        RESET = 1'b0;
        step(0, 0, '0, '0);
        chk_outputs_zero("after_reset");
        step(0, 0, '0, '0);

        // single write with latency check
        c0 = cyc + 1;
        step(1, 1, 7'h25, 32'hDEADBEEF);
        step(0, 0, '0, '0);
        step(0, 0, '0, '0);
        chk("write_latency", 32'(last_hsel_cyc), 32'(c0 + 2));
        drain();

        // single read
        force_rd_en = 1; force_rd = 32'h0000_00A5; force_n = 0;
        step(1, 0, 7'h41, 32'h1234_5678);
        drain();
        force_rd_en = 0; force_n = -1;

        // back-to-back pushes with the bus stalled
        idle_mode = 2;
        base = n_acc;
        for (int i = 0; i < 5; i++) step(1, 1, 7'(8'h10 + i), $urandom);
        step(0, 0, '0, '0);
        chk("full_refuse_ready", 32'(cmd_ready), 0);
        chk("accepted_four", 32'(n_acc - base), 4);
        idle_mode = 1;
        drain();

        // wait states then timeout
        force_n = 3;
        step(1, 1, 7'h33, 32'hCAFE_F00D);
        drain();
        force_n = TMO;
        step(1, 0, 7'h62, '0);
        drain();
        force_n = -1;
        step(1, 0, 7'h05, '0);
        drain();

        // reset during data phase, then normal traffic
        reset_in_data();
        step(1, 1, 7'h2A, 32'h0BAD_F00D);
        drain();

        // randomized traffic
        idle_mode = 0;
        for (int i = 0; i < 500; i++) begin
            step(($urandom % 3) != 0, $urandom % 2, $urandom, $urandom);
        end
        idle_mode = 1;
        drain();
        chk("final_exp_empty", 32'(exp_q.size()), 0);
        chk("final_cmd_empty", 32'(cmd_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
